// File: rtl/lutram_chk_pkg.sv
// rtl/lutram_chk_pkg.sv - shared types for the LUTRAM read checker
package lutram_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic PORT_SPO = 1'b0;
    localparam logic PORT_DPO = 1'b1;

endpackage

// File: rtl/lutram_shadow_model.sv
// rtl/lutram_shadow_model.sv - shadow copy of the LUTRAM under test with per-entry valid bits
module lutram_shadow_model
    import lutram_chk_pkg::*;
#(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               we,
    input  logic [A_WIDTH-1:0] wa,
    input  logic [D_WIDTH-1:0] wd,
    input  logic [A_WIDTH-1:0] ra0,
    input  logic [A_WIDTH-1:0] ra1,
    output logic               valid0,
    output logic [D_WIDTH-1:0] data0,
    output logic               valid1,
    output logic [D_WIDTH-1:0] data1
);

    localparam int DEPTH = 1 << A_WIDTH;

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]   valid;

    // Data needs no reset: an entry is only ever read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid <= '0;
        end else if (we) begin
            valid[wa] <= 1'b1;
        end
    end

    assign valid0 = valid[ra0];
    assign data0  = mem[ra0];
    assign valid1 = valid[ra1];
    assign data1  = mem[ra1];

endmodule

// File: rtl/lutram_read_checker.sv
// rtl/lutram_read_checker.sv - scoreboard comparing LUTRAM SPO/DPO reads against a shadow model
module lutram_read_checker
    import lutram_chk_pkg::*;
#(
    parameter int A_WIDTH   = 5,
    parameter int D_WIDTH   = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 end_i,
    input  logic                 we_i,
    input  logic [A_WIDTH-1:0]   a_i,
    input  logic [A_WIDTH-1:0]   dpra_i,
    input  logic [D_WIDTH-1:0]   d_i,
    input  logic                 rd_en_i,
    input  logic [D_WIDTH-1:0]   spo_i,
    input  logic [D_WIDTH-1:0]   dpo_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 fail_o,
    output logic [CNT_WIDTH-1:0] err_count_o,
    output logic [CNT_WIDTH-1:0] check_count_o,
    output logic [A_WIDTH-1:0]   first_err_addr_o,
    output logic                 first_err_port_o
);

    state_t state;
    state_t state_next;

    logic                 active;
    logic                 spo_valid;
    logic [D_WIDTH-1:0]   spo_ref;
    logic                 dpo_valid;
    logic [D_WIDTH-1:0]   dpo_ref;
    logic                 spo_chk;
    logic                 dpo_chk;
    logic                 spo_bad;
    logic                 dpo_bad;
    logic [1:0]           chk_inc;
    logic [1:0]           err_inc;
    logic [CNT_WIDTH-1:0] chk_next;
    logic [CNT_WIDTH-1:0] err_next;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = RUN;
            RUN:     if (start_i) state_next = RUN;
                     else if (end_i) state_next = DONE;
            DONE:    if (start_i) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // A restart cycle only clears; its write and read strobes are dropped.
    assign active = (state == RUN) && !start_i;

    lutram_shadow_model #(
        .A_WIDTH (A_WIDTH),
        .D_WIDTH (D_WIDTH)
    ) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_i),
        .we     (active && we_i),
        .wa     (a_i),
        .wd     (d_i),
        .ra0    (a_i),
        .ra1    (dpra_i),
        .valid0 (spo_valid),
        .data0  (spo_ref),
        .valid1 (dpo_valid),
        .data1  (dpo_ref)
    );

    // Shadow reads are async, so a same-cycle write is compared against the old contents.
    assign spo_chk = active && rd_en_i && spo_valid;
    assign dpo_chk = active && rd_en_i && dpo_valid;
    assign spo_bad = spo_chk && (spo_i != spo_ref);
    assign dpo_bad = dpo_chk && (dpo_i != dpo_ref);

    assign chk_inc = {1'b0, spo_chk} + {1'b0, dpo_chk};
    assign err_inc = {1'b0, spo_bad} + {1'b0, dpo_bad};

    assign chk_next = start_i ? '0 : sat_add(check_count_o, chk_inc);
    assign err_next = start_i ? '0 : sat_add(err_count_o, err_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            fail_o           <= 1'b0;
            err_count_o      <= '0;
            check_count_o    <= '0;
            first_err_addr_o <= '0;
            first_err_port_o <= PORT_SPO;
        end else begin
            busy_o        <= (state_next == RUN);
            done_o        <= (state_next == DONE);
            pass_o        <= (state_next == DONE) && (err_next == '0) && (chk_next != '0);
            err_count_o   <= err_next;
            check_count_o <= chk_next;
            if (start_i) begin
                fail_o           <= 1'b0;
                first_err_addr_o <= '0;
                first_err_port_o <= PORT_SPO;
            end else if (!fail_o && spo_bad) begin
                fail_o           <= 1'b1;
                first_err_addr_o <= a_i;
                first_err_port_o <= PORT_SPO;
            end else if (!fail_o && dpo_bad) begin
                fail_o           <= 1'b1;
                first_err_addr_o <= dpra_i;
                first_err_port_o <= PORT_DPO;
            end
        end
    end

endmodule

// File: tb/tb_lutram_read_checker.sv
// tb/tb_lutram_read_checker.sv - randomized self-checking bench for lutram_read_checker
module tb_lutram_read_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       end_i = 1'b0;
    logic       we_i = 1'b0;
    logic [4:0] a_i = '0;
    logic [4:0] dpra_i = '0;
    logic       d_i = 1'b0;
    logic       rd_en_i = 1'b0;
    logic       spo_i = 1'b0;
    logic       dpo_i = 1'b0;

    logic        busy, done, pass, fail, fport;
    logic [15:0] errc, chkc;
    logic [4:0]  faddr;
    logic        busy4, done4, pass4, fail4, fport4;
    logic [3:0]  errc4, chkc4;
    logic [4:0]  faddr4;

    int checks = 0;
    int errors = 0;

    // Reference model: session mode, shadow contents, raw counts, first error.
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
    int mode;
    bit sh [32];
    bit vm [32];
    bit ram [32];
    int chk_m, err_m;
    bit fail_m;
    int fa_m;
    bit fp_m;

    lutram_read_checker #(.A_WIDTH(5), .D_WIDTH(1), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .end_i(end_i), .we_i(we_i),
        .a_i(a_i), .dpra_i(dpra_i), .d_i(d_i), .rd_en_i(rd_en_i),
        .spo_i(spo_i), .dpo_i(dpo_i),
        .busy_o(busy), .done_o(done), .pass_o(pass), .fail_o(fail),
        .err_count_o(errc), .check_count_o(chkc),
        .first_err_addr_o(faddr), .first_err_port_o(fport)
    );

    lutram_read_checker #(.A_WIDTH(5), .D_WIDTH(1), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start_i(start_i), .end_i(end_i), .we_i(we_i),
        .a_i(a_i), .dpra_i(dpra_i), .d_i(d_i), .rd_en_i(rd_en_i),
        .spo_i(spo_i), .dpo_i(dpo_i),
        .busy_o(busy4), .done_o(done4), .pass_o(pass4), .fail_o(fail4),
        .err_count_o(errc4), .check_count_o(chkc4),
        .first_err_addr_o(faddr4), .first_err_port_o(fport4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) vm[i] = 1'b0;
        chk_m = 0; err_m = 0; fail_m = 1'b0; fa_m = 0; fp_m = 1'b0;
    endtask

    task automatic note_err(input int addr, input bit port);
        err_m++;
        if (!fail_m) begin
            fail_m = 1'b1; fa_m = addr; fp_m = port;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            mode = M_IDLE;
            clear_model();
        end else if (start_i) begin
            mode = M_RUN;
            clear_model();
        end else if (mode == M_RUN) begin
            if (rd_en_i) begin
                if (vm[a_i]) begin
                    chk_m++;
                    if (spo_i != sh[a_i]) note_err(int'(a_i), 1'b0);
                end
                if (vm[dpra_i]) begin
                    chk_m++;
                    if (dpo_i != sh[dpra_i]) note_err(int'(dpra_i), 1'b1);
                end
            end
            if (we_i) begin
                sh[a_i] = d_i;
                vm[a_i] = 1'b1;
            end
            if (end_i) mode = M_DONE;
        end
        if (we_i) ram[a_i] = d_i;
    endtask

    task automatic compare_all();
        bit pass_m;
        pass_m = (mode == M_DONE) && (err_m == 0) && (chk_m != 0);
        check("busy", busy, mode == M_RUN);
        check("done", done, mode == M_DONE);
        check("pass", pass, pass_m);
        check("fail", fail, fail_m);
        check("err_count", errc, sat(err_m, 65535));
        check("check_count", chkc, sat(chk_m, 65535));
        check("first_err_addr", faddr, fa_m);
        check("first_err_port", fport, fp_m);
        check("busy4", busy4, mode == M_RUN);
        check("done4", done4, mode == M_DONE);
        check("pass4", pass4, pass_m);
        check("fail4", fail4, fail_m);
        check("err_count4", errc4, sat(err_m, 15));
        check("check_count4", chkc4, sat(chk_m, 15));
        check("first_err_addr4", faddr4, fa_m);
        check("first_err_port4", fport4, fp_m);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        rst = 1'b0; start_i = 1'b0; end_i = 1'b0; we_i = 1'b0; rd_en_i = 1'b0;
    endtask

    task automatic set_reads(input bit flip_s, input bit flip_d);
        spo_i = ram[a_i] ^ flip_s;
        dpo_i = ram[dpra_i] ^ flip_d;
    endtask

    task automatic pulse_start();
        idle_inputs(); start_i = 1'b1; step(); start_i = 1'b0;
    endtask

    task automatic pulse_end();
        idle_inputs(); end_i = 1'b1; step(); end_i = 1'b0; step();
    endtask

    task automatic write(input int addr, input bit val);
        idle_inputs(); we_i = 1'b1; a_i = 5'(addr); d_i = val; step(); we_i = 1'b0;
    endtask

    task automatic read(input int addr, input int daddr, input bit flip_s, input bit flip_d);
        idle_inputs(); rd_en_i = 1'b1; a_i = 5'(addr); dpra_i = 5'(daddr);
        set_reads(flip_s, flip_d); step(); rd_en_i = 1'b0;
    endtask

    initial begin
        mode = M_IDLE;
        clear_model();
        for (int i = 0; i < 32; i++) begin sh[i] = 1'b0; ram[i] = 1'b0; end

        rst = 1'b1; step(); step();
        check("reset_busy", busy, 0);
        check("reset_err", errc, 0);
        idle_inputs();

        // All zeros, full sweep on both ports.
        pulse_start();
        for (int i = 0; i < 32; i++) write(i, 1'b0);
        for (int i = 0; i < 32; i++) read(i, i, 1'b0, 1'b0);
        pulse_end();
        check("t1_pass", pass, 1);
        check("t1_checks", chkc, 64);
        check("t1_err", errc, 0);

        // Checkerboard with one SPO fault at address 7.
        pulse_start();
        for (int i = 0; i < 32; i++) write(i, i[0]);
        for (int i = 0; i < 32; i++) read(i, i, i == 7, 1'b0);
        pulse_end();
        check("t2_fail", fail, 1);
        check("t2_err", errc, 1);
        check("t2_addr", faddr, 7);
        check("t2_port", fport, 0);
        check("t2_pass", pass, 0);

        // Reads with nothing written are not counted.
        pulse_start();
        for (int i = 0; i < 5; i++) read(i, 31 - i, 1'b1, 1'b1);
        pulse_end();
        check("t3_checks", chkc, 0);
        check("t3_err", errc, 0);
        check("t3_pass", pass, 0);
        check("t3_fail", fail, 0);
        check("t3_done", done, 1);

        // Read-before-write on the same address.
        pulse_start();
        write(3, 1'b0);
        idle_inputs(); we_i = 1'b1; rd_en_i = 1'b1; a_i = 5'd3; dpra_i = 5'd3; d_i = 1'b1;
        spo_i = 1'b0; dpo_i = 1'b0; step();
        idle_inputs(); rd_en_i = 1'b1; spo_i = 1'b1; dpo_i = 1'b1; step();
        idle_inputs();
        check("t4_err", errc, 0);
        check("t4_checks", chkc, 4);
        pulse_end();

        // Counter saturation in the 4-bit instance.
        pulse_start();
        write(0, 1'b0);
        for (int i = 0; i < 20; i++) read(0, 0, 1'b1, 1'b0);
        check("t5_err4", errc4, 15);
        check("t5_err16", errc, 20);
        step();
        check("t5_err4_hold", errc4, 15);
        pulse_end();

        // Reset mid-session, then a clean pass.
        pulse_start();
        write(1, 1'b1);
        read(1, 1, 1'b1, 1'b1);
        check("t6_err_before", errc, 2);
        rst = 1'b1; step(); rst = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_fail", fail, 0);
        check("t6_err", errc, 0);
        check("t6_checks", chkc, 0);
        pulse_start();
        for (int i = 0; i < 4; i++) write(i, i[1]);
        for (int i = 0; i < 4; i++) read(i, 3 - i, 1'b0, 1'b0);
        pulse_end();
        check("t6_pass", pass, 1);

        // Randomized traffic with occasional restarts, ends and resets.
        pulse_start();
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            rst     = ($urandom_range(0, 399) == 0);
            start_i = ($urandom_range(0, 79) == 0);
            end_i   = ($urandom_range(0, 59) == 0);
            we_i    = 1'($urandom_range(0, 1));
            a_i     = 5'($urandom_range(0, 31));
            dpra_i  = 5'($urandom_range(0, 31));
            d_i     = 1'($urandom_range(0, 1));
            rd_en_i = ($urandom_range(0, 9) < 6);
            set_reads($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
            step();
        end
        pulse_end();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
